// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone register-file slave and its benches.
//   op_t / ret_t : bus operation and termination kinds used by traffic generators
//   state_t      : slave FSM states
//   sel_width, idx_shift : derive lane count and word-index shift from bus geometry
//   sel_merge    : lane-wise merge of two data words under a select mask
package wb_pkg;

    typedef enum logic [1:0] {OpIdle, OpRead, OpWrite} op_t;
    typedef enum logic [1:0] {RetNone, RetAck, RetErr} ret_t;
    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    // Widest bus the generic merge helper handles; callers zero-extend into it.
    localparam int unsigned MaxDataWidth = 256;
    localparam int unsigned MaxSelWidth  = 256;

    function automatic int unsigned sel_width(input int unsigned dw, input int unsigned gr);
        return dw / gr;
    endfunction

    function automatic int unsigned idx_shift(input int unsigned sw);
        return (sw > 1) ? $clog2(sw) : 0;
    endfunction

    // Bit b takes new_v when its lane (b / granule) is selected, else keeps old_v.
    function automatic logic [MaxDataWidth-1:0] sel_merge(
        input logic [MaxDataWidth-1:0] old_v,
        input logic [MaxDataWidth-1:0] new_v,
        input logic [MaxSelWidth-1:0]  sel,
        input int unsigned             granule
    );
        logic [MaxDataWidth-1:0] res;
        res = old_v;
        for (int unsigned b = 0; b < MaxDataWidth; b++) begin
            if (sel[b / granule]) begin
                res[b] = new_v[b];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_sel_merge.sv
// Combinational byte-lane merge: each lane of merged_o comes from new_i when its
// sel_i bit is set, otherwise from old_i. With old_i = 0 it acts as a read mask.
//   old_i    : value kept on unselected lanes
//   new_i    : value taken on selected lanes
//   sel_i    : one bit per GRANULE-wide lane
//   merged_o : merged result
module wb_sel_merge
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned GRANULE    = 8
) (
    input  logic [DATA_WIDTH-1:0]         old_i,
    input  logic [DATA_WIDTH-1:0]         new_i,
    input  logic [DATA_WIDTH/GRANULE-1:0] sel_i,
    output logic [DATA_WIDTH-1:0]         merged_o
);

    always_comb begin
        merged_o = DATA_WIDTH'(sel_merge(MaxDataWidth'(old_i), MaxDataWidth'(new_i),
                                         MaxSelWidth'(sel_i), GRANULE));
    end

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone B4 slave register file with programmable wait states, classic or
// pipelined handshake, byte-lane writes and hardware-driven read-only slots.
//   clk_i, rst_i      : clock, asynchronous active-low reset
//   adr_i, dat_i      : byte address and write data
//   sel_i, we_i       : lane select and write enable
//   cyc_i, stb_i      : bus cycle and strobe
//   dat_o             : registered read data (valid with ack_o)
//   ack_o, err_o      : one-cycle registered terminations, mutually exclusive
//   stall_o           : busy indication in pipelined mode, 0 in classic mode
//   status_i          : hardware values shown by read-only slots
//   regs_o            : current view of every slot (RO slots mirror status_i)
module wb_slave_regfile
    import wb_pkg::*;
#(
    parameter int unsigned         ADDR_WIDTH  = 16,
    parameter int unsigned         DATA_WIDTH  = 32,
    parameter int unsigned         GRANULE     = 8,
    parameter int unsigned         NUM_REGS    = 8,
    parameter int unsigned         WAIT_STATES = 1,
    parameter int unsigned         PIPELINED   = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = NUM_REGS'('h80)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [ADDR_WIDTH-1:0]          adr_i,
    input  logic [DATA_WIDTH-1:0]          dat_i,
    output logic [DATA_WIDTH-1:0]          dat_o,
    input  logic [DATA_WIDTH/GRANULE-1:0]  sel_i,
    input  logic                           we_i,
    input  logic                           cyc_i,
    input  logic                           stb_i,
    output logic                           ack_o,
    output logic                           err_o,
    output logic                           stall_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int unsigned SelWidth = sel_width(DATA_WIDTH, GRANULE);
    localparam int unsigned IdxShift = idx_shift(SelWidth);
    localparam int unsigned IdxWidth = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned RoPadW   = 2 ** IdxWidth;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IdxWidth-1:0]   idx_q;
    logic                  we_q;
    logic [SelWidth-1:0]   sel_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  req_err_q;
    logic                  ack_q, err_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] view;

    // Request decode on the live bus
    logic [ADDR_WIDTH-1:0] idx_full;
    logic [IdxWidth-1:0]   idx_in;
    logic [RoPadW-1:0]     ro_pad;
    logic                  misaligned, out_of_range, req_err, accept;

    assign idx_full     = adr_i >> IdxShift;
    assign idx_in       = idx_full[IdxWidth-1:0];
    assign ro_pad       = RoPadW'(RO_MASK);
    assign misaligned   = (adr_i & ADDR_WIDTH'(SelWidth - 1)) != '0;
    assign out_of_range = {1'b0, idx_full} >= (ADDR_WIDTH + 1)'(NUM_REGS);
    assign req_err      = misaligned | out_of_range | (we_i & ro_pad[idx_in]);

    assign stall_o = (PIPELINED != 0) && (state_q != StIdle);
    assign accept  = (state_q == StIdle) && cyc_i && stb_i && !stall_o;

    // With zero wait states RESP is entered on the acceptance edge, so the
    // commit/read path must see the live request rather than the latched copy.
    logic                  cur_we, cur_err;
    logic [IdxWidth-1:0]   cur_idx;
    logic [SelWidth-1:0]   cur_sel;
    logic [DATA_WIDTH-1:0] cur_dat;

    always_comb begin
        if (state_q == StIdle) begin
            cur_idx = idx_in;
            cur_we  = we_i;
            cur_sel = sel_i;
            cur_dat = dat_i;
            cur_err = req_err;
        end else begin
            cur_idx = idx_q;
            cur_we  = we_q;
            cur_sel = sel_q;
            cur_dat = dat_q;
            cur_err = req_err_q;
        end
    end

    logic go_resp, commit;
    assign go_resp = (accept && (WAIT_STATES == 0)) ||
                     ((state_q == StWait) && cyc_i && (cnt_q == 4'd1));
    assign commit  = go_resp && cur_we && !cur_err;

    logic [DATA_WIDTH-1:0] wmerged, rmasked;

    wb_sel_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .GRANULE    (GRANULE)
    ) u_wr_merge (
        .old_i    (regs_q[cur_idx]),
        .new_i    (cur_dat),
        .sel_i    (cur_sel),
        .merged_o (wmerged)
    );

    wb_sel_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .GRANULE    (GRANULE)
    ) u_rd_mask (
        .old_i    ('0),
        .new_i    (view[cur_idx]),
        .sel_i    (cur_sel),
        .merged_o (rmasked)
    );

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_slot
        if (RO_MASK[k]) begin : g_ro
            assign view[k] = status_i[k*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_rw
            logic unused_status;
            assign view[k]       = regs_q[k];
            assign unused_status = ^status_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end
    assign regs_o = view;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? StResp : StWait;
                end
            end
            StWait: begin
                if (!cyc_i) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign rdata_d = (go_resp && !cur_err && !cur_we) ? rmasked : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            dat_q     <= '0;
            req_err_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= go_resp && !cur_err;
            err_q   <= go_resp && cur_err;
            rdata_q <= rdata_d;
            if (accept) begin
                idx_q     <= idx_in;
                we_q      <= we_i;
                sel_q     <= sel_i;
                dat_q     <= dat_i;
                req_err_q <= req_err;
            end
            // Errors cover RO slots, so commit only ever touches RW registers.
            if (commit) regs_q[cur_idx] <= wmerged;
        end
    end

    assign ack_o = ack_q;
    assign err_o = err_q;
    assign dat_o = rdata_q;

endmodule

// File: tb/tb_wb_slave_regfile.sv
module tb_wb_slave_regfile;

    localparam int NDUT = 3;
    localparam int NREG = 8;

    function automatic int ws_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int pipe_of(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  adr    [NDUT];
    logic [31:0]  dat_w  [NDUT];
    logic [31:0]  dat_r  [NDUT];
    logic [3:0]   sel    [NDUT];
    logic         we     [NDUT];
    logic         cyc    [NDUT];
    logic         stb    [NDUT];
    logic         ack    [NDUT];
    logic         err    [NDUT];
    logic         stall  [NDUT];
    logic [255:0] status [NDUT];
    logic [255:0] regs   [NDUT];

    logic [31:0]  mreg [NDUT][NREG];
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        wb_slave_regfile #(
            .ADDR_WIDTH  (16),
            .DATA_WIDTH  (32),
            .GRANULE     (8),
            .NUM_REGS    (8),
            .WAIT_STATES (ws_of(g)),
            .PIPELINED   (pipe_of(g)),
            .RO_MASK     (8'h80)
        ) u_dut (
            .clk_i    (clk),
            .rst_i    (rst_n),
            .adr_i    (adr[g]),
            .dat_i    (dat_w[g]),
            .dat_o    (dat_r[g]),
            .sel_i    (sel[g]),
            .we_i     (we[g]),
            .cyc_i    (cyc[g]),
            .stb_i    (stb[g]),
            .ack_o    (ack[g]),
            .err_o    (err[g]),
            .stall_o  (stall[g]),
            .status_i (status[g]),
            .regs_o   (regs[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: slot 7 is read-only and shows the status input.
    function automatic logic [31:0] view(input int k, input int idx);
        if (idx == 7) return status[k][224 +: 32];
        return mreg[k][idx];
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m = '0;
        for (int j = 0; j < 4; j++) if (s[j]) m |= 32'hFF << (8 * j);
        return m;
    endfunction

    function automatic bit exp_err(input logic w, input logic [15:0] a);
        int idx = int'(a) / 4;
        if (int'(a) % 4 != 0) return 1'b1;
        if (idx >= NREG) return 1'b1;
        return w && (idx == 7);
    endfunction

    task automatic check_regs(input int k, input string tag);
        for (int i = 0; i < NREG; i++)
            check($sformatf("%s d%0d reg%0d", tag, k, i), regs[k][i*32 +: 32], view(k, i));
    endtask

    task automatic clear_model();
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < NREG; i++) mreg[k][i] = '0;
    endtask

    task automatic idle_bus(input int k);
        adr[k] = '0; dat_w[k] = '0; sel[k] = '0; we[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0;
    endtask

    // One bus transaction; returns termination, read data and edges to response.
    task automatic xfer(input int k, input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic g_ack, output logic g_err,
                        output logic [31:0] g_dat, output int lat);
        adr[k] = a; dat_w[k] = d; sel[k] = s; we[k] = w; cyc[k] = 1'b1; stb[k] = 1'b1;
        g_ack = 1'b0; g_err = 1'b0; g_dat = '0; lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1 && pipe_of(k) != 0) stb[k] = 1'b0;
            if (ack[k] || err[k]) begin
                g_ack = ack[k]; g_err = err[k]; g_dat = dat_r[k]; lat = c;
                break;
            end
        end
        idle_bus(k);
        @(posedge clk); #1;
        check($sformatf("d%0d after-resp ack/err", k), {30'd0, ack[k], err[k]}, 32'd0);
        check($sformatf("d%0d after-resp dat", k), dat_r[k], 32'd0);
    endtask

    task automatic do_txn(input int k, input logic w, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        logic        g_ack, g_err;
        logic [31:0] g_dat, exp_dat, m;
        int          lat;
        bit          e;
        string       t;
        e = exp_err(w, a);
        m = lane_mask(s);
        exp_dat = (e || w) ? 32'd0 : (view(k, int'(a) / 4) & m);
        t = $sformatf("d%0d %s @%04h sel %h", k, w ? "wr" : "rd", a, s);
        xfer(k, w, a, d, s, g_ack, g_err, g_dat, lat);
        check({t, " latency"}, lat, ws_of(k) + 1);
        check({t, " ack"}, {31'd0, g_ack}, {31'd0, !e});
        check({t, " err"}, {31'd0, g_err}, {31'd0, e});
        if (!w) check({t, " data"}, g_dat, exp_dat);
        if (w && !e) mreg[k][int'(a) / 4] = (mreg[k][int'(a) / 4] & ~m) | (d & m);
        check_regs(k, t);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) idle_bus(k);
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        int          r;
        logic        any;
        for (int k = 0; k < NDUT; k++) begin
            idle_bus(k);
            status[k] = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
        end
        apply_reset();
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("d%0d reset ack/err", k), {30'd0, ack[k], err[k]}, 32'd0);
            check($sformatf("d%0d reset dat", k), dat_r[k], 32'd0);
            check($sformatf("d%0d reset stall", k), {31'd0, stall[k]}, 32'd0);
            check_regs(k, "reset");
        end

        // Classic, one wait state
        do_txn(0, 1'b0, 16'h0004, 32'h0, 4'hF);
        do_txn(0, 1'b1, 16'h0008, 32'hDEADBEEF, 4'h5);
        check("partial write reg2", regs[0][2*32 +: 32], 32'h00AD00EF);
        do_txn(0, 1'b0, 16'h0008, 32'h0, 4'hF);
        do_txn(0, 1'b0, 16'h0008, 32'h0, 4'h2);
        status[0][224 +: 32] = 32'hCAFE0001;
        do_txn(0, 1'b1, 16'h001C, 32'h12345678, 4'hF);
        check("ro slot unchanged", regs[0][7*32 +: 32], 32'hCAFE0001);
        do_txn(0, 1'b0, 16'h001C, 32'h0, 4'hF);
        do_txn(0, 1'b0, 16'h0020, 32'h0, 4'hF);
        do_txn(0, 1'b1, 16'h0005, 32'hFFFFFFFF, 4'hF);
        do_txn(0, 1'b1, 16'h0008, 32'h01020304, 4'h0);

        // Pipelined, zero wait states: back-to-back request stalls until idle
        adr[1] = 16'h0000; dat_w[1] = 32'h11111111; sel[1] = 4'hF; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk); #1;
        check("pipe wr ack", {31'd0, ack[1]}, 32'd1);
        check("pipe busy stall", {31'd0, stall[1]}, 32'd1);
        we[1] = 1'b0;
        @(posedge clk); #1;
        check("pipe gap ack", {31'd0, ack[1]}, 32'd0);
        check("pipe idle stall", {31'd0, stall[1]}, 32'd0);
        @(posedge clk); #1;
        check("pipe rd ack", {31'd0, ack[1]}, 32'd1);
        check("pipe rd data", dat_r[1], 32'h11111111);
        check("pipe rd stall", {31'd0, stall[1]}, 32'd1);
        idle_bus(1);
        @(posedge clk); #1;
        mreg[1][0] = 32'h11111111;
        check_regs(1, "pipe");

        // Abort: cyc dropped after one wait cycle
        adr[2] = 16'h000C; dat_w[2] = 32'h22222222; sel[2] = 4'hF; we[2] = 1'b1;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        idle_bus(2);
        any = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            any |= ack[2] | err[2];
        end
        check("abort no term", {31'd0, any}, 32'd0);
        check("abort reg3", regs[2][3*32 +: 32], 32'd0);
        check("abort dat", dat_r[2], 32'd0);
        do_txn(2, 1'b0, 16'h000C, 32'h0, 4'hF);

        // Randomised traffic on every configuration
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 4) == 0) status[k][224 +: 32] = $urandom;
                r = $urandom_range(0, 9);
                if (r < 7)       a = 16'($urandom_range(0, 7) * 4);
                else if (r == 7) a = 16'($urandom_range(8, 15) * 4);
                else             a = 16'($urandom_range(0, 31));
                do_txn(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            end
        end

        // Reset while DUT0 is responding and DUT2 is waiting
        do_txn(0, 1'b1, 16'h0004, 32'hA5A5A5A5, 4'hF);
        adr[0] = 16'h0004; sel[0] = 4'hF; we[0] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
        adr[2] = 16'h0010; dat_w[2] = 32'h33333333; sel[2] = 4'hF; we[2] = 1'b1;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("pre-reset ack", {31'd0, ack[0]}, 32'd1);
        check("pre-reset data", dat_r[0], 32'hA5A5A5A5);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("d%0d async reset ack/err", k), {30'd0, ack[k], err[k]}, 32'd0);
            check($sformatf("d%0d async reset dat", k), dat_r[k], 32'd0);
            check_regs(k, "async reset");
            idle_bus(k);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_txn(2, 1'b0, 16'h0010, 32'h0, 4'hF);
        do_txn(0, 1'b0, 16'h0004, 32'h0, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
